// File: rtl/regfile_wb_pkg.sv
// regfile_wb_pkg: shared widths, arbitration state and default starvation limit
package regfile_wb_pkg;
    localparam int REG_W = 5;
    localparam int NREG = 32;
    localparam int STARVE_MAX_DEF = 4;
    typedef enum logic {PRIO_A, FORCE_B} arb_state_t;
endpackage

// File: rtl/decoder_5to32.sv
// decoder_5to32: 5-to-32 one-hot decoder with enable
module decoder_5to32 import regfile_wb_pkg::*; (
    input  logic             en,
    input  logic [REG_W-1:0] sel,
    output logic [NREG-1:0]  dec
);
    assign dec = en ? NREG'(1) << sel : '0;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: two-port write-back arbiter, one-hot rf write stage and multdiv busy scoreboard
// WB_STARVE_GUARD_EN enables forcing port B after STARVE_MAX consecutive losses
module regfile_wb_arbiter import regfile_wb_pkg::*; #(
    parameter int NREG = regfile_wb_pkg::NREG,
    parameter int DW = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [REG_W-1:0] a_rd,
    input  logic [DW-1:0]    a_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [REG_W-1:0] b_rd,
    input  logic [DW-1:0]    b_data,
    input  logic             iss_valid,
    input  logic [REG_W-1:0] iss_rd,
    output logic [NREG-1:0]  busy,
    output logic [NREG-1:0]  rf_we,
    output logic [REG_W-1:0] rf_wrd,
    output logic [DW-1:0]    rf_wdata
);
    arb_state_t state;
    logic a_hs, b_hs, hs, wr;
    logic [REG_W-1:0] win_rd;
    logic [DW-1:0] win_data;
    logic [NREG-1:0] win_dec, set_vec, clr_vec;

    assign a_ready = state == PRIO_A;
    assign b_ready = state == FORCE_B ? 1'b1 : b_valid & ~a_valid;
    assign a_hs = a_valid & a_ready;
    assign b_hs = b_valid & b_ready;
    assign hs = a_hs | b_hs;
    assign win_rd = a_hs ? a_rd : b_rd;
    assign win_data = a_hs ? a_data : b_data;
    // register 0 completes the handshake but is never written
    assign wr = hs && win_rd != '0;

    decoder_5to32 u_dec (.en(1'b1), .sel(win_rd), .dec(win_dec));

    assign set_vec = iss_valid && iss_rd != '0 ? NREG'(1) << iss_rd : '0;
    assign clr_vec = b_hs ? NREG'(1) << b_rd : '0;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rf_we <= '0;
            rf_wrd <= '0;
            rf_wdata <= '0;
            busy <= '0;
        end else begin
            rf_we <= win_dec & {NREG{wr}};
            if (wr) begin
                rf_wrd <= win_rd;
                rf_wdata <= win_data;
            end
            busy <= (busy & ~clr_vec) | set_vec;
        end
    end

`ifdef WB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_MAX + 1);
    arb_state_t state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= PRIO_A;
            cnt <= '0;
        end else begin
            state <= state_nxt;
            cnt <= cnt_nxt;
        end
    end

    always_comb begin
        cnt_nxt = b_hs || !b_valid ? '0 : state == PRIO_A && a_valid ? cnt + 1'b1 : cnt;
        state_nxt = state == PRIO_A ? (cnt_nxt == CW'(STARVE_MAX) ? FORCE_B : PRIO_A)
                                    : (b_hs || !b_valid ? PRIO_A : FORCE_B);
    end
`else
    assign state = PRIO_A;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed stimulus with a write scoreboard checked by a negedge monitor
module tb_regfile_wb_arbiter;
    logic clock = 1'b0;
    logic resetn = 1'b0;
    logic a_valid, b_valid, iss_valid;
    logic a_ready, b_ready;
    logic [4:0] a_rd, b_rd, iss_rd, rf_wrd;
    logic [31:0] a_data, b_data, busy, rf_we, rf_wdata;

    typedef struct {
        logic [31:0] we;
        logic [4:0] rd;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t e;
    int checks = 0;
    int passed = 0;

    always #5 clock = ~clock;

    regfile_wb_arbiter dut (
        .clock(clock), .resetn(resetn),
        .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .busy(busy), .rf_we(rf_we), .rf_wrd(rf_wrd), .rf_wdata(rf_wdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic push(input logic [31:0] we, input logic [4:0] rd, input logic [31:0] data);
        exp_q.push_back('{we, rd, data});
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic mid;
        @(negedge clock);
    endtask

    always @(negedge clock) begin
        if (rf_we !== '0) begin
            if (exp_q.size() == 0) chk("unexpected_write", rf_we, 32'h0);
            else begin
                e = exp_q.pop_front();
                chk("wr_we", rf_we, e.we);
                chk("wr_rd", 32'(rf_wrd), 32'(e.rd));
                chk("wr_data", rf_wdata, e.data);
            end
        end
    end

    initial begin
        a_valid = 0; b_valid = 0; iss_valid = 0;
        a_rd = 0; b_rd = 0; iss_rd = 0; a_data = 0; b_data = 0;
        #3;
        chk("rst_we", rf_we, 32'h0);
        chk("rst_busy", busy, 32'h0);
        chk("rst_a_ready", 32'(a_ready), 32'h1);
        chk("rst_b_ready", 32'(b_ready), 32'h0);
        step; step; resetn = 1;

        step; a_valid = 1; a_rd = 5; a_data = 32'hDEADBEEF; push(32'h0000_0020, 5, 32'hDEADBEEF);
        mid; chk("a_ready_single", 32'(a_ready), 32'h1);
        step; a_valid = 0;
        mid;
        step; mid;
        chk("we_clear", rf_we, 32'h0);
        chk("hold_wrd", 32'(rf_wrd), 32'h5);
        chk("hold_wdata", rf_wdata, 32'hDEADBEEF);

        step; a_valid = 1; a_rd = 0; a_data = 32'h12345678;
        mid; chk("a_ready_rd0", 32'(a_ready), 32'h1);
        step; a_valid = 0;
        mid; chk("rd0_no_write", rf_we, 32'h0);

        step; iss_valid = 1; iss_rd = 9;
        step; iss_valid = 0; b_valid = 1; b_rd = 9; b_data = 32'hCAFEF00D; push(32'h0000_0200, 9, 32'hCAFEF00D);
        mid; chk("busy_set", busy, 32'h0000_0200); chk("b_ready_idle", 32'(b_ready), 32'h1);
        step; b_valid = 0;
        mid; chk("busy_clr", busy, 32'h0);
        step; iss_valid = 1; iss_rd = 9; b_valid = 1; b_rd = 9; b_data = 32'h0BADC0DE; push(32'h0000_0200, 9, 32'h0BADC0DE);
        mid; chk("b_ready_setclr", 32'(b_ready), 32'h1);
        step; iss_valid = 0; b_valid = 0;
        mid; chk("busy_set_wins", busy, 32'h0000_0200);
        step; b_valid = 1; b_data = 32'h11111111; push(32'h0000_0200, 9, 32'h11111111);
        step; b_valid = 0;
        mid; chk("busy_clr2", busy, 32'h0);
        step; iss_valid = 1; iss_rd = 0;
        step; iss_valid = 0;
        mid; chk("busy_rd0", busy, 32'h0);

        step; a_valid = 1; a_rd = 3; b_valid = 1; b_rd = 7; b_data = 32'hB7B7B7B7;
        for (int i = 0; i < 3; i++) begin
            a_data = 32'hA000_0000 + i; push(32'h0000_0008, 3, 32'hA000_0000 + i);
            mid; chk("a_ready_cont", 32'(a_ready), 32'h1); chk("b_ready_cont", 32'(b_ready), 32'h0);
            step;
        end
        a_valid = 0; push(32'h0000_0080, 7, 32'hB7B7B7B7);
        mid; chk("b_ready_free", 32'(b_ready), 32'h1);
        step; b_valid = 0;
        mid;

        step; a_valid = 1; b_valid = 1; a_rd = 3; b_rd = 7; b_data = 32'hD7D7D7D7;
`ifdef WB_STARVE_GUARD_EN
        for (int i = 0; i < 4; i++) begin
            a_data = 32'hC000_0000 + i; push(32'h0000_0008, 3, 32'hC000_0000 + i);
            mid; chk("a_ready_prio", 32'(a_ready), 32'h1); chk("b_ready_prio", 32'(b_ready), 32'h0);
            step;
        end
        push(32'h0000_0080, 7, 32'hD7D7D7D7);
        mid; chk("a_ready_force", 32'(a_ready), 32'h0); chk("b_ready_force", 32'(b_ready), 32'h1);
        step; b_valid = 0; a_data = 32'hC0000009; push(32'h0000_0008, 3, 32'hC0000009);
        mid; chk("a_ready_back", 32'(a_ready), 32'h1);
        step; a_valid = 0;
`else
        for (int i = 0; i < 8; i++) begin
            a_data = 32'hC000_0000 + i; push(32'h0000_0008, 3, 32'hC000_0000 + i);
            mid; chk("b_starved", 32'(b_ready), 32'h0);
            step;
        end
        a_valid = 0; push(32'h0000_0080, 7, 32'hD7D7D7D7);
        mid; chk("b_ready_late", 32'(b_ready), 32'h1);
        step; b_valid = 0;
`endif
        mid;

        step; iss_valid = 1; iss_rd = 9;
        step; iss_rd = 10;
        step; iss_valid = 0; a_valid = 1; a_rd = 4; a_data = 32'h55AA55AA;
        mid; chk("busy_pre_reset", busy, 32'h0000_0600);
        step; a_data = 32'h66BB66BB;
        #1; chk("pre_reset_we", rf_we, 32'h0000_0010);
        resetn = 0;
        #1;
        chk("arst_busy", busy, 32'h0);
        chk("arst_we", rf_we, 32'h0);
        chk("arst_wdata", rf_wdata, 32'h0);
        chk("arst_wrd", 32'(rf_wrd), 32'h0);
        chk("arst_a_ready", 32'(a_ready), 32'h1);
        a_valid = 0;
        step; step; resetn = 1;
        a_valid = 1; b_valid = 1; a_rd = 6; a_data = 32'h00000077; b_rd = 7; b_data = 32'h00000088;
        push(32'h0000_0040, 6, 32'h00000077);
        mid; chk("post_rst_a_ready", 32'(a_ready), 32'h1); chk("post_rst_b_ready", 32'(b_ready), 32'h0);
        step; a_valid = 0; push(32'h0000_0080, 7, 32'h00000088);
        step; b_valid = 0;
        mid; step; mid;
        chk("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
